// File: rtl/timer_array.sv
// Bank of NCH independent down-counting timers with a small word-addressed register bus.
// Ports: clk/reset (async, active-low); we/addr/wdata write port; rdata combinational read;
//        irq[NCH-1:0] per-channel level interrupt (pending AND IM), irq_any = OR of irq.
module timer_array #(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [NCH-1:0]   irq,
  output logic             irq_any
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_t;

  localparam logic [2:0] NCH_L = 3'(NCH);

  logic [1:0]           sel_ch;
  logic [1:0]           sel_reg;
  logic                 ch_ok;
  logic [NCH-1:0][31:0] rd_val;

  assign sel_ch  = addr[3:2];
  assign sel_reg = addr[1:0];
  // Channels at or above NCH have no instance below, so writes to them match nothing.
  assign ch_ok   = ({1'b0, sel_ch} < NCH_L);

  genvar i;
  generate
    for (i = 0; i < NCH; i++) begin : g_ch
      localparam logic [1:0] IDX = 2'(i);

      state_t           state_q, state_d;
      logic             en_q, mode_q, im_q;
      logic [2:0]       ps_q;
      logic [CNT_W-1:0] preset_q, count_q;
      logic [6:0]       psc_q, psc_max;
      logic             pend_q;
      logic             hit, wr_ctrl, wr_preset, wr_status;
      logic             tick, cnt_zero;
      logic             do_load, do_dec, do_set, do_clr_en, psc_run;
      logic [31:0]      rd_ch;

      assign hit       = we && (sel_ch == IDX);
      assign wr_ctrl   = hit && (sel_reg == 2'd0);
      assign wr_preset = hit && (sel_reg == 2'd1);
      assign wr_status = hit && (sel_reg == 2'd3);

      // 2^PS - 1; for PS=7 the shift overflows to 0 and the subtract wraps to 127.
      assign psc_max  = (7'd1 << ps_q) - 7'd1;
      assign tick     = (psc_q == psc_max);
      assign cnt_zero = (count_q == '0);

      // State register
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
      end

      // Next-state logic: clearing EN drops any active state back to IDLE
      always_comb begin
        state_d = state_q;
        case (state_q)
          ST_IDLE: if (en_q) state_d = ST_LOAD;
          ST_LOAD: state_d = en_q ? ST_CNT : ST_IDLE;
          ST_CNT: begin
            if (!en_q)                 state_d = ST_IDLE;
            else if (tick && cnt_zero) state_d = ST_INT;
          end
          ST_INT:  state_d = (en_q && mode_q) ? ST_LOAD : ST_IDLE;
          default: state_d = ST_IDLE;
        endcase
      end

      // Output decode: datapath controls for this cycle
      always_comb begin
        do_load   = (state_q == ST_LOAD) && en_q;
        psc_run   = (state_q == ST_CNT) && en_q;
        do_dec    = psc_run && tick && !cnt_zero;
        do_set    = psc_run && tick && cnt_zero;
        do_clr_en = (state_q == ST_INT) && en_q && !mode_q;
      end

      // Datapath registers
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          en_q     <= 1'b0;
          mode_q   <= 1'b0;
          im_q     <= 1'b0;
          ps_q     <= 3'd0;
          preset_q <= '0;
          count_q  <= '0;
          psc_q    <= 7'd0;
          pend_q   <= 1'b0;
        end else begin
          // A software CTRL write takes precedence over the one-shot EN clear.
          if (wr_ctrl) begin
            en_q   <= wdata[0];
            mode_q <= wdata[1];
            im_q   <= wdata[3];
            ps_q   <= wdata[6:4];
          end else if (do_clr_en) begin
            en_q <= 1'b0;
          end

          if (wr_preset) preset_q <= wdata[CNT_W-1:0];

          if (do_load)     count_q <= preset_q;
          else if (do_dec) count_q <= count_q - CNT_W'(1);

          // CTRL writes restart the prescaler so a new PS takes effect from a clean phase.
          if (do_load || wr_ctrl) psc_q <= 7'd0;
          else if (psc_run)       psc_q <= tick ? 7'd0 : psc_q + 7'd1;

          // Hardware set beats a same-cycle W1C.
          if (do_set)                      pend_q <= 1'b1;
          else if (wr_status && wdata[0])  pend_q <= 1'b0;
        end
      end

      always_comb begin
        rd_ch = '0;
        case (sel_reg)
          2'd0: rd_ch = {25'd0, ps_q, im_q, 1'b0, mode_q, en_q};
          2'd1: rd_ch = 32'(preset_q);
          2'd2: rd_ch = 32'(count_q);
          2'd3: rd_ch = {31'd0, pend_q};
          default: rd_ch = '0;
        endcase
      end

      assign rd_val[i] = rd_ch;
      assign irq[i]    = pend_q & im_q;
    end
  endgenerate

  always_comb begin
    rdata = '0;
    if (ch_ok) begin
      for (int k = 0; k < NCH; k++) begin
        if (sel_ch == 2'(k)) rdata = rd_val[k];
      end
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_array.sv
module tb_timer_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  irq;
  logic        irq_any;

  int n_chk = 0;
  int n_err = 0;

  timer_array #(.NCH(2), .CNT_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .irq_any (irq_any)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a write mid-cycle; it is taken at the next rising edge. Returns 1 ns after that edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    addr = a; #1; d = rdata;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    we = 1'b0; addr = 4'd0; wdata = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #5 reset = 1'b1;
  endtask

  // Reference model, from the timing rules: with tick spacing L = 2^PS, the k-th tick
  // lands at W+2+k*L; tick P+1 sets pending, then INT + LOAD add two cycles per period.
  function automatic int exp_cnt(input int t, input int p, input int lsz, input bit mode);
    int tp = (p + 1) * lsz;
    int u;
    if (t < 2) return 0;
    u = t - 2;
    if (mode) u = u % (tp + 2);
    if (u >= tp) return 0;
    return p - u / lsz;
  endfunction

  function automatic bit exp_pend(input int t, input int p, input int lsz);
    return t >= 2 + (p + 1) * lsz;
  endfunction

  function automatic bit exp_en(input int t, input int p, input int lsz, input bit mode);
    return mode || (t <= 2 + (p + 1) * lsz);
  endfunction

  task automatic run_scn(input int ch, input int p, input int ps, input bit mode, input bit im);
    logic [1:0]  cb, ob;
    logic [31:0] v, ctrl;
    int          lsz, ncyc;
    bit          pe, en;
    cb   = 2'(ch);
    ob   = 2'(1 - ch);
    lsz  = 1 << ps;
    ncyc = 2 * ((p + 1) * lsz + 2) + 6;
    do_reset();
    wr({cb, 2'd1}, 32'(p));
    wr({cb, 2'd0}, (32'(ps) << 4) | (32'(im) << 3) | (32'(mode) << 1) | 32'd1);
    for (int t = 0; t <= ncyc; t++) begin
      if (t > 0) step();
      pe   = exp_pend(t, p, lsz);
      en   = exp_en(t, p, lsz, mode);
      ctrl = (32'(ps) << 4) | (32'(im) << 3) | (32'(mode) << 1) | 32'(en);
      check("irq",     32'(irq),     32'(pe && im) << ch);
      check("irq_any", 32'(irq_any), 32'(pe && im));
      rd({cb, 2'd2}, v); check("count",  v, 32'(exp_cnt(t, p, lsz, mode)));
      rd({cb, 2'd3}, v); check("status", v, 32'(pe));
      rd({cb, 2'd0}, v); check("ctrl",   v, ctrl);
      rd({ob, 2'd2}, v); check("other_count",  v, 32'd0);
      rd({ob, 2'd3}, v); check("other_status", v, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] v;
    int          c;

    // Reset state
    do_reset();
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_irq_any", 32'(irq_any), 32'd0);
    for (int a = 0; a < 8; a++) begin
      rd(4'(a), v); check("rst_reg", v, 32'd0);
    end

    // Directed timing cases then randomized ones
    run_scn(0, 5, 0, 1'b0, 1'b1);   // one-shot, P=5
    run_scn(1, 3, 0, 1'b1, 1'b1);   // auto-reload, period 6
    run_scn(0, 2, 2, 1'b0, 1'b1);   // prescale by 4
    run_scn(0, 0, 0, 1'b1, 1'b1);   // preset 0
    run_scn(1, 4, 1, 1'b1, 1'b0);   // masked interrupt
    for (int s = 0; s < 10; s++)
      run_scn(int'($urandom_range(0, 1)), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // W1C clears, but loses to a same-cycle set
    do_reset();
    wr(4'h5, 32'd3);
    wr(4'h4, 32'hB);
    repeat (5) step();                                   // t=5
    rd(4'h7, v); check("w1c_pre", v, 32'd0);
    step();                                              // t=6
    rd(4'h7, v); check("w1c_set1", v, 32'd1);
    check("w1c_irq1", 32'(irq), 32'd2);
    wr(4'h7, 32'd1);                                     // t=7
    rd(4'h7, v); check("w1c_clr", v, 32'd0);
    check("w1c_irq_clr", 32'(irq), 32'd0);
    wr(4'h7, 32'd0);                                     // t=8, write 0 is no-op
    repeat (3) step();                                   // t=11
    rd(4'h7, v); check("w1c_mid", v, 32'd0);
    wr(4'h7, 32'd1);                                     // t=12, collides with set
    rd(4'h7, v); check("w1c_collide", v, 32'd1);
    check("w1c_collide_irq", 32'(irq_any), 32'd1);
    repeat (6) step();                                   // t=18
    rd(4'h7, v); check("w1c_set3", v, 32'd1);

    // Disable mid-count, preset change deferred to next load
    do_reset();
    wr(4'h1, 32'd100);
    wr(4'h0, 32'h9);
    repeat (41) step();                                  // t=41
    rd(4'h2, v); check("dis_cnt41", v, 32'd61);
    wr(4'h0, 32'd0);                                     // t=42
    rd(4'h2, v); check("dis_cnt42", v, 32'd60);
    wr(4'h1, 32'd40);                                    // t=43
    wr(4'h2, 32'h1234);                                  // COUNT is read-only
    for (int k = 0; k < 6; k++) begin
      step();
      rd(4'h2, v); check("dis_frozen", v, 32'd60);
      rd(4'h3, v); check("dis_pend", v, 32'd0);
      check("dis_irq", 32'(irq), 32'd0);
    end
    wr(4'h0, 32'h9);
    rd(4'h2, v); check("reen_t0", v, 32'd60);
    step();
    rd(4'h2, v); check("reen_t1", v, 32'd60);
    step();
    rd(4'h2, v); check("reen_load", v, 32'd40);
    step();
    rd(4'h2, v); check("reen_dec", v, 32'd39);

    // Asynchronous reset with irq high, checked before any further clock edge
    do_reset();
    wr(4'h1, 32'd2);
    wr(4'h0, 32'hB);
    repeat (5) step();
    check("ar_irq_before", 32'(irq), 32'd1);
    reset = 1'b0;
    #1;
    check("ar_irq", 32'(irq), 32'd0);
    check("ar_irq_any", 32'(irq_any), 32'd0);
    rd(4'h0, v); check("ar_ctrl", v, 32'd0);
    rd(4'h1, v); check("ar_preset", v, 32'd0);
    rd(4'h2, v); check("ar_count", v, 32'd0);
    rd(4'h3, v); check("ar_status", v, 32'd0);

    // Out-of-range channels, reserved bits, masked pending
    do_reset();
    wr(4'h1, 32'd7);
    wr(4'h5, 32'hDEAD_BEEF);
    wr(4'hC, 32'h9);
    wr(4'hD, 32'hFF);
    wr(4'h8, 32'h9);
    for (int a = 8; a < 16; a++) begin
      rd(4'(a), v); check("oor_read", v, 32'd0);
    end
    rd(4'h1, v); check("oor_p0", v, 32'd7);
    rd(4'h5, v); check("oor_p1", v, 32'hDEAD_BEEF);
    rd(4'h0, v); check("oor_c0", v, 32'd0);
    rd(4'h4, v); check("oor_c1", v, 32'd0);
    wr(4'h4, 32'hFFFF_FF7E);
    rd(4'h4, v); check("ctrl_rsvd", v, 32'h0000_007A);
    wr(4'h4, 32'd0);
    wr(4'h1, 32'd0);
    wr(4'h0, 32'h1);                                     // EN, one-shot, IM=0
    c = 0;
    repeat (4) begin step(); c++; end                    // t=4
    rd(4'h3, v); check("mask_pend", v, 32'd1);
    check("mask_irq", 32'(irq), 32'd0);
    check("mask_irq_any", 32'(irq_any), 32'd0);
    rd(4'h0, v); check("mask_en_clr", v, 32'd0);
    wr(4'h0, 32'h8);                                     // IM on, EN off
    check("unmask_irq", 32'(irq), 32'd1);
    check("unmask_irq_any", 32'(irq_any), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
